maze_move_ctrl: RTL and testbench
=================================

// Module: maze_move_ctrl
// PURPOSE
//  Consumes the level-type key flags (up/down/left/right/enter) from the PS/2 keyboard decoder.
//  Turns key presses into discrete player-move requests with typematic auto-repeat.
//  Checks each candidate cell against maze bounds and the maze wall map (req/ack handshake),
//  then holds the committed player position (pos_x/pos_y) used by the VGA renderer and game FSM.
// PARAMETERS
//  REPEAT_DELAY  25_000_000  cycles from a key's first move event to its first repeat event
//  REPEAT_PERIOD 10_000_000  cycles between subsequent repeat events while the key is held
//  MAZE_W        32          maze width in cells; legal x = 0..MAZE_W-1
//  MAZE_H        24          maze height in cells; legal y = 0..MAZE_H-1
//  XW / YW       5 / 5       widths of the x / y coordinate buses
//  START_X / START_Y  1 / 1  player position after reset or on restart
// PORTS
//  clk          in   1   system clock
//  rst          in   1   reset, asynchronous, active-high
//  up,down,left,right in 1  key-held levels from the PS/2 decoder (same clk domain)
//  enter        in   1   enter-held level from the PS/2 decoder
//  game_en      in   1   1 = moves allowed; 0 = key events are discarded
//  restart      in   1   1-cycle pulse: return to START_X/START_Y, drop pending and in-flight moves
//  wall_req     out  1   wall lookup request, held high until wall_ack
//  wall_x       out  XW  candidate cell x, stable while wall_req=1
//  wall_y       out  YW  candidate cell y, stable while wall_req=1
//  wall_ack     in   1   lookup done; wall_blocked is valid in the same cycle
//  wall_blocked in   1   1 = candidate cell is a wall
//  pos_x        out  XW  committed player x
//  pos_y        out  YW  committed player y
//  moved        out  1   1-cycle pulse in the cycle pos_x/pos_y change
//  bumped       out  1   1-cycle pulse when a move is rejected (wall or out of bounds)
//  enter_pulse  out  1   1-cycle pulse on each enter rising edge (ignores game_en)
//  busy         out  1   FSM is not in IDLE
// BEHAVIOUR
//  Reset values: pos=(START_X,START_Y); wall_req, moved, bumped, enter_pulse and busy = 0;
//   wall_x/y = 0; FSM = IDLE; pending slot empty; repeat timer = 0; previous-key regs = 0.
//   Reset asserted mid-handshake drops wall_req immediately.
//  Event generation:
//   - Each key is registered once per cycle; a rising edge in cycle N produces a move event in N+1.
//   - If several keys rise in the same cycle, priority is up > down > left > right; the others
//     are ignored.
//   - The key that produced the latest event becomes the active key, and its repeat timer restarts.
//   - While the active key stays high, repeat events fire at E+REPEAT_DELAY, then every
//     REPEAT_PERIOD cycles.
//   - Releasing the active key stops repeats. Other keys still held do not repeat until
//     they are pressed again.
//   - Events with game_en=0 are discarded, and the active key is cleared.
//  Pending slot (1 entry):
//   - An event is written to the slot.
//   - If the slot is already full, the new event is dropped and the older one is kept.
//   - IDLE consumes the slot.
//  FSM:
//   - IDLE: if the slot is full, compute the target as pos plus a +/-1 delta (up: y-1,
//     down: y+1, left: x-1, right: x+1).
//       - Out of bounds (x=0 moving left, x=MAZE_W-1 moving right, same rule for y):
//         pulse bumped, stay in IDLE, no lookup.
//       - Otherwise: drive wall_x/y with the target, set wall_req=1, go to REQ.
//   - REQ: hold wall_req and wall_x/y. On wall_ack: wall_req=0 next cycle, go to COMMIT.
//     The wall_blocked value sampled with the ack is stored.
//   - COMMIT (1 cycle): if not blocked, pos=target and moved=1; otherwise bumped=1. Return to IDLE.
//   - Latency: key edge at N -> wall_req at N+2 (slot empty, FSM idle);
//     ack at A -> pos/moved at A+1.
//  restart:
//   - Has priority over everything else in the same cycle.
//   - pos=START, slot cleared, FSM=IDLE, wall_req=0 next cycle.
//   - A wall_ack arriving after that is ignored.
//  Arithmetic: deltas are computed in XW/YW bits; the bounds check happens before the add,
//   so no wrap-around can occur.
// TESTING
//  Use REPEAT_DELAY=10, REPEAT_PERIOD=4, MAZE 8x8, START (1,1), and a wall model that acks
//  2 cycles after the request.
//  1. right rises at cycle 0, wall model returns no wall -> wall_req at cycle 2 with (2,1);
//     pos=(2,1) and moved pulse one cycle after the ack.
//  2. Hold down for 30 cycles from (1,1), no walls -> move events at E, E+10, E+14, E+18,
//     E+22, E+26; final y=7; further repeats bump.
//  3. left pressed at x=0 -> bumped pulse, no wall_req, pos unchanged.
//  4. up with wall_blocked=1 -> bumped at ack+1, pos unchanged; then up with blocked=0 -> y-1.
//  5. up and left rise in the same cycle -> only the up lookup is issued. Three presses
//     during one lookup -> exactly 2 moves (in-flight + pending).
//  6. Assert restart, or rst, while wall_req=1 -> wall_req low, pos=(1,1), a late ack changes
//     nothing; enter rising -> 1-cycle enter_pulse.

Source files
------------

// File: rtl/maze_move_if.sv
// Wall-map lookup handshake between the move controller (master) and the maze wall ROM (slave).
interface maze_move_if #(
  parameter int XW = 5,
  parameter int YW = 5
);
  logic          wall_req;
  logic [XW-1:0] wall_x;
  logic [YW-1:0] wall_y;
  logic          wall_ack;
  logic          wall_blocked;

  modport master (output wall_req, wall_x, wall_y, input  wall_ack, wall_blocked);
  modport slave  (input  wall_req, wall_x, wall_y, output wall_ack, wall_blocked);
endinterface

// File: rtl/maze_move_ctrl.sv
// Key flags -> auto-repeating move events -> bounds + wall check -> committed player position.
module maze_move_ctrl #(
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int MAZE_W        = 32,
  parameter int MAZE_H        = 24,
  parameter int XW            = 5,
  parameter int YW            = 5,
  parameter int START_X       = 1,
  parameter int START_Y       = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_up,
  input  logic          i_down,
  input  logic          i_left,
  input  logic          i_right,
  input  logic          i_enter,
  input  logic          i_game_en,
  input  logic          i_restart,
  maze_move_if.master   wall,
  output logic [XW-1:0] o_pos_x,
  output logic [YW-1:0] o_pos_y,
  output logic          o_moved,
  output logic          o_bumped,
  output logic          o_enter_pulse,
  output logic          o_busy
);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {DIR_UP, DIR_DN, DIR_LT, DIR_RT} dir_e;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_COMMIT} st_e;

  // Key edge detection; bit index of w_keys equals dir_e encoding
  logic [3:0] w_keys, w_rise, r_key_prev;
  logic       r_enter_prev;
  logic       w_rise_any;
  dir_e       w_rise_dir;

  assign w_keys        = {i_right, i_left, i_down, i_up};
  assign w_rise        = w_keys & ~r_key_prev;
  assign o_enter_pulse = i_enter & ~r_enter_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_prev   <= '0;
      r_enter_prev <= 1'b0;
    end else begin
      r_key_prev   <= w_keys;
      r_enter_prev <= i_enter;
    end
  end

  always_comb begin
    w_rise_any = |w_rise;
    w_rise_dir = DIR_RT;
    if      (w_rise[0]) w_rise_dir = DIR_UP;
    else if (w_rise[1]) w_rise_dir = DIR_DN;
    else if (w_rise[2]) w_rise_dir = DIR_LT;
  end

  // Typematic repeat: r_tmr counts cycles since the last event of the active key
  logic          r_act_vld, r_first;
  dir_e          r_act_dir;
  logic [TW-1:0] r_tmr;
  logic          w_rpt, w_evt;
  dir_e          w_evt_dir;

  assign w_rpt     = r_act_vld & w_keys[r_act_dir] &
                     (r_tmr == (r_first ? TW'(REPEAT_DELAY) : TW'(REPEAT_PERIOD)));
  assign w_evt     = w_rise_any | w_rpt;
  assign w_evt_dir = w_rise_any ? w_rise_dir : r_act_dir;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act_vld <= 1'b0;
      r_act_dir <= DIR_UP;
      r_first   <= 1'b0;
      r_tmr     <= '0;
    end else if (i_restart || (w_evt && !i_game_en)) begin
      r_act_vld <= 1'b0;
      r_tmr     <= '0;
    end else if (w_rise_any) begin
      r_act_vld <= 1'b1;
      r_act_dir <= w_rise_dir;
      r_first   <= 1'b1;
      r_tmr     <= TW'(1);
    end else if (w_rpt) begin
      r_first   <= 1'b0;
      r_tmr     <= TW'(1);
    end else if (r_act_vld && !w_keys[r_act_dir]) begin
      r_act_vld <= 1'b0;
      r_tmr     <= '0;
    end else if (r_act_vld) begin
      r_tmr     <= r_tmr + TW'(1);
    end
  end

  // One-entry pending slot; a full slot drops newer events, even in the cycle it drains
  st_e           r_state, w_state_nxt;
  logic          r_slot_vld;
  dir_e          r_slot_dir;
  logic          w_take;

  assign w_take = (r_state == S_IDLE) & r_slot_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_vld <= 1'b0;
      r_slot_dir <= DIR_UP;
    end else if (i_restart) begin
      r_slot_vld <= 1'b0;
    end else if (!r_slot_vld) begin
      if (w_evt && i_game_en) begin
        r_slot_vld <= 1'b1;
        r_slot_dir <= w_evt_dir;
      end
    end else if (w_take) begin
      r_slot_vld <= 1'b0;
    end
  end

  // Target cell; bounds are checked before the +/-1 so the add never wraps
  logic [XW-1:0] r_pos_x, r_wall_x, w_tx;
  logic [YW-1:0] r_pos_y, r_wall_y, w_ty;
  logic          w_oob, r_blk;

  always_comb begin
    w_tx  = r_pos_x;
    w_ty  = r_pos_y;
    w_oob = 1'b0;
    case (r_slot_dir)
      DIR_UP: begin w_oob = (r_pos_y == '0);               w_ty = r_pos_y - YW'(1); end
      DIR_DN: begin w_oob = (r_pos_y == YW'(MAZE_H - 1));  w_ty = r_pos_y + YW'(1); end
      DIR_LT: begin w_oob = (r_pos_x == '0);               w_tx = r_pos_x - XW'(1); end
      DIR_RT: begin w_oob = (r_pos_x == XW'(MAZE_W - 1));  w_tx = r_pos_x + XW'(1); end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_restart) w_state_nxt = S_IDLE;
    else begin
      case (r_state)
        S_IDLE:   if (r_slot_vld && !w_oob) w_state_nxt = S_REQ;
        S_REQ:    if (wall.wall_ack)        w_state_nxt = S_COMMIT;
        S_COMMIT: w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    wall.wall_req = (r_state == S_REQ);
    o_busy        = (r_state != S_IDLE);
    o_moved       = (r_state == S_COMMIT) & ~r_blk;
    o_bumped      = ((r_state == S_COMMIT) & r_blk) | (w_take & w_oob & ~i_restart);
  end

  // Position lands on the ack edge so it changes in the same cycle moved is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pos_x  <= XW'(START_X);
      r_pos_y  <= YW'(START_Y);
      r_wall_x <= '0;
      r_wall_y <= '0;
      r_blk    <= 1'b0;
    end else if (i_restart) begin
      r_pos_x  <= XW'(START_X);
      r_pos_y  <= YW'(START_Y);
      r_blk    <= 1'b0;
    end else begin
      if (w_take && !w_oob) begin
        r_wall_x <= w_tx;
        r_wall_y <= w_ty;
      end
      if (r_state == S_REQ && wall.wall_ack) begin
        r_blk <= wall.wall_blocked;
        if (!wall.wall_blocked) begin
          r_pos_x <= r_wall_x;
          r_pos_y <= r_wall_y;
        end
      end
    end
  end

  assign wall.wall_x = r_wall_x;
  assign wall.wall_y = r_wall_y;
  assign o_pos_x     = r_pos_x;
  assign o_pos_y     = r_pos_y;
endmodule

// File: tb/tb_maze_move_ctrl.sv
// Directed bench for maze_move_ctrl: 8x8 maze, short repeat timing, wall model acking 2 cycles after req.
module tb_maze_move_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       kup, kdn, klt, krt, kent, gen, rstrt;
  logic [4:0] pos_x, pos_y;
  logic       moved, bumped, enter_pulse, busy;

  always #5 clk = ~clk;

  maze_move_if #(.XW(5), .YW(5)) wif ();

  maze_move_ctrl #(
    .REPEAT_DELAY(10), .REPEAT_PERIOD(4), .MAZE_W(8), .MAZE_H(8),
    .XW(5), .YW(5), .START_X(1), .START_Y(1)
  ) dut (
    .clk(clk), .rst(rst),
    .i_up(kup), .i_down(kdn), .i_left(klt), .i_right(krt),
    .i_enter(kent), .i_game_en(gen), .i_restart(rstrt),
    .wall(wif.master),
    .o_pos_x(pos_x), .o_pos_y(pos_y),
    .o_moved(moved), .o_bumped(bumped), .o_enter_pulse(enter_pulse), .o_busy(busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Wall ROM model: ack two cycles after wall_req rises, or by hand when auto_ack=0
  logic auto_ack = 1'b1, blk_cfg = 1'b0, m_ack = 1'b0, man_ack = 1'b0, wdone = 1'b0;
  int   wcnt = 0;
  assign wif.wall_ack     = m_ack | man_ack;
  assign wif.wall_blocked = blk_cfg;

  always @(negedge clk) begin
    m_ack = 1'b0;
    if (!wif.wall_req) begin
      wcnt  = 0;
      wdone = 1'b0;
    end else if (auto_ack && !wdone) begin
      if (wcnt == 2) begin m_ack = 1'b1; wdone = 1'b1; end
      else wcnt++;
    end
  end

  // Event recorder: cycle numbers of pulses and request starts
  int   mv_q[$], bp_q[$], rq_q[$], ep_q[$];
  int   rq_x, rq_y;
  logic req_d = 1'b0;
  always @(negedge clk) begin
    if (wif.wall_req && !req_d) begin
      rq_q.push_back(cyc);
      rq_x = int'(wif.wall_x);
      rq_y = int'(wif.wall_y);
    end
    req_d = wif.wall_req;
    if (moved)       mv_q.push_back(cyc);
    if (bumped)      bp_q.push_back(cyc);
    if (enter_pulse) ep_q.push_back(cyc);
  end

  int n_vec = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    mv_q.delete(); bp_q.delete(); rq_q.delete(); ep_q.delete();
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  int e;
  int mv_exp[6] = '{5, 15, 20, 25, 30, 35};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; kup = 0; kdn = 0; klt = 0; krt = 0; kent = 0; gen = 1; rstrt = 0;
    tick(2);
    chk("rst_pos_x", pos_x, 1);
    chk("rst_pos_y", pos_y, 1);
    chk("rst_req", wif.wall_req, 0);
    chk("rst_wx", wif.wall_x, 0);
    chk("rst_busy", busy, 0);
    chk("rst_moved", moved, 0);
    chk("rst_bumped", bumped, 0);
    chk("rst_enter", enter_pulse, 0);
    rst = 1'b0;
    tick(2);

    // 1: single right move, latency of request and commit
    clr(); e = cyc; krt = 1; tick(); krt = 0;
    chk("t1_req_n1", wif.wall_req, 0);
    tick();
    chk("t1_req_n2", wif.wall_req, 1);
    chk("t1_wx", wif.wall_x, 2);
    chk("t1_wy", wif.wall_y, 1);
    tick(2);
    chk("t1_pos_ack", pos_x, 1);
    chk("t1_mv_ack", moved, 0);
    tick();
    chk("t1_pos_x", pos_x, 2);
    chk("t1_pos_y", pos_y, 1);
    chk("t1_mv", moved, 1);
    tick();
    chk("t1_mv_end", moved, 0);

    // restart back to start, then 2: held down with auto-repeat
    rstrt = 1; tick(); rstrt = 0;
    chk("rs_pos_x", pos_x, 1);
    chk("rs_pos_y", pos_y, 1);
    clr(); e = cyc; kdn = 1; tick(36); kdn = 0; tick(12);
    chk("t2_nmv", mv_q.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("t2_mv%0d", i), qat(mv_q, i) - e, mv_exp[i]);
    chk("t2_nbp", bp_q.size(), 1);
    chk("t2_bp", qat(bp_q, 0) - e, 36);
    chk("t2_pos_y", pos_y, 7);
    chk("t2_pos_x", pos_x, 1);

    // 3: left to x=0, then left again bumps at the edge
    klt = 1; tick(); klt = 0; tick(8);
    chk("t3_pos_x0", pos_x, 0);
    clr(); e = cyc; klt = 1; tick(); klt = 0; tick(6);
    chk("t3_nbp", bp_q.size(), 1);
    chk("t3_bp", qat(bp_q, 0) - e, 1);
    chk("t3_nrq", rq_q.size(), 0);
    chk("t3_pos_x", pos_x, 0);

    // 4: up into a wall, then up into free cell
    blk_cfg = 1; clr(); e = cyc; kup = 1; tick(); kup = 0; tick(8);
    chk("t4_nbp", bp_q.size(), 1);
    chk("t4_bp", qat(bp_q, 0) - e, 5);
    chk("t4_nmv", mv_q.size(), 0);
    chk("t4_pos_y", pos_y, 7);
    blk_cfg = 0; clr(); kup = 1; tick(); kup = 0; tick(8);
    chk("t4_pos_y2", pos_y, 6);
    chk("t4_nmv2", mv_q.size(), 1);

    // 5: simultaneous up+left, then three presses during one lookup
    clr(); kup = 1; klt = 1; tick(); kup = 0; klt = 0; tick(8);
    chk("t5_nrq", rq_q.size(), 1);
    chk("t5_rqx", rq_x, 0);
    chk("t5_rqy", rq_y, 5);
    chk("t5_nbp", bp_q.size(), 0);
    chk("t5_pos_y", pos_y, 5);
    clr(); krt = 1; tick(); krt = 0; tick(); kdn = 1; tick(); kdn = 0; krt = 1; tick(); krt = 0;
    tick(14);
    chk("t5_nmv3", mv_q.size(), 2);
    chk("t5_nrq3", rq_q.size(), 2);
    chk("t5_pos_x3", pos_x, 1);
    chk("t5_pos_y3", pos_y, 6);

    // 6: restart mid-handshake, late ack ignored
    auto_ack = 0; clr(); kdn = 1; tick(); kdn = 0; tick(2);
    chk("t6_req", wif.wall_req, 1);
    tick(2);
    chk("t6_req_hold", wif.wall_req, 1);
    rstrt = 1; tick(); rstrt = 0;
    chk("t6_req_rs", wif.wall_req, 0);
    chk("t6_busy_rs", busy, 0);
    chk("t6_pos_rs", {pos_x, pos_y}, {5'd1, 5'd1});
    man_ack = 1; tick(); man_ack = 0; tick(3);
    chk("t6_late_mv", mv_q.size(), 0);
    chk("t6_late_pos", {pos_x, pos_y}, {5'd1, 5'd1});

    // rst mid-handshake drops wall_req without a clock edge
    clr(); krt = 1; tick(); krt = 0; tick(2);
    chk("t6_req2", wif.wall_req, 1);
    rst = 1; #1;
    chk("t6_req_rst", wif.wall_req, 0);
    tick(); rst = 0; tick();
    man_ack = 1; tick(); man_ack = 0; tick(3);
    chk("t6_rst_mv", mv_q.size(), 0);
    chk("t6_rst_pos", {pos_x, pos_y}, {5'd1, 5'd1});
    chk("t6_rst_busy", busy, 0);
    auto_ack = 1;

    // enter pulse ignores game_en; moves are discarded while disabled
    gen = 0; clr(); e = cyc; kent = 1; tick(4); kent = 0; tick(2);
    chk("t6_nep", ep_q.size(), 1);
    chk("t6_ep", qat(ep_q, 0) - e, 0);
    clr(); krt = 1; tick(); krt = 0; tick(6);
    chk("t6_dis_rq", rq_q.size(), 0);
    chk("t6_dis_pos", pos_x, 1);
    gen = 1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
